// File: rtl/audio_pwm_out.sv
// rtl/audio_pwm_out.sv - stereo sample FIFO, rate divider and first-order sigma-delta 1-bit outputs
module audio_pwm_out #(
  parameter int DEPTH     = 8,
  parameter int W_DIV     = 12,
  parameter int WATERMARK = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [W_DIV-1:0]         rate_div,
  input  logic [31:0]              sample_wdata,
  input  logic                     sample_wvld,
  output logic                     sample_wrdy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     fifo_low,
  output logic                     underrun,
  input  logic                     underrun_clr,
  output logic                     audio_l,
  output logic                     audio_r
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] WM = WATERMARK[AW:0];

  logic [31:0]      mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             tick;
  logic [W_DIV-1:0] cnt;
  logic [31:0]      cur_sample;
  logic [15:0]      acc_l;
  logic [15:0]      acc_r;
  logic [16:0]      sum_l;
  logic [16:0]      sum_r;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty       = (wptr == rptr);
  assign full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign sample_wrdy = !full;
  assign fifo_level  = wptr - rptr;
  assign fifo_low    = (fifo_level <= WM);

  assign push = sample_wvld && !full;
  assign tick = enable && (cnt == rate_div);
  assign pop  = tick && !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= sample_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Equality-only wrap: a rate_div lowered below cnt lets cnt run to all-ones first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (!enable || tick) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cur_sample <= '0;
    else if (!enable) cur_sample <= '0;
    else if (pop)     cur_sample <= mem[rptr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 underrun <= 1'b0;
    else if (tick && empty)  underrun <= 1'b1;
    else if (underrun_clr)   underrun <= 1'b0;
  end

  // Offset-binary input: the carry-out duty equals u/65536.
  assign sum_l = {1'b0, acc_l} + {1'b0, cur_sample[31:16] ^ 16'h8000};
  assign sum_r = {1'b0, acc_r} + {1'b0, cur_sample[15:0]  ^ 16'h8000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_l   <= '0;
      acc_r   <= '0;
      audio_l <= 1'b0;
      audio_r <= 1'b0;
    end else if (!enable) begin
      acc_l   <= '0;
      acc_r   <= '0;
      audio_l <= 1'b0;
      audio_r <= 1'b0;
    end else begin
      acc_l   <= sum_l[15:0];
      acc_r   <= sum_r[15:0];
      audio_l <= sum_l[16];
      audio_r <= sum_r[16];
    end
  end

endmodule
